// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM-like bus responder: size encodings, LFSR taps,
// request-entry field widths and the LFSR step function.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  localparam int WSTRB_W = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;

  // Galois form, right-shifting, taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order request queue for the responder; each entry carries a latency countdown
// and the head reports ready once its countdown has drained to zero.
module sram_resp_fifo
  import sram_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic [CNT_W-1:0] push_cnt,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_ready,
  output logic [W-1:0]     head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [W-1:0]     data_q [DEPTH];
  logic [CNT_W-1:0] cd_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  // Countdowns age every cycle; a freshly pushed entry starts at push_cnt unaged
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      for (int i = 0; i < DEPTH; i++) cd_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cd_q[i] != '0) cd_q[i] <= cd_q[i] - 1'b1;
      end
      if (push) begin
        cd_q[wr_ptr]    <= push_cnt;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr] <= push_data;
  end

  assign full       = (occ == FULL_OCC);
  assign empty      = (occ == '0);
  assign head_ready = valid_q[rd_ptr] && (cd_q[rd_ptr] == '0);
  assign head_data  = data_q[rd_ptr];

endmodule

// File: rtl/sram_like_resp.sv
// Memory responder for the SRAM-like req/addr_ok/data_ok bus with in-order completion.
// Define SRAM_RESP_RAND_EN to add LFSR-driven random stalls on accept and completion.
module sram_like_resp
  import sram_resp_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          LATENCY   = 2,
  parameter int          MEM_AW    = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int ENTRY_W = 1 + WSTRB_W + MEM_AW + DATA_W;
  localparam logic [CNT_W-1:0] INIT_CD = CNT_W'(LATENCY - 1);

  logic               full;
  logic               empty;
  logic               head_ready;
  logic [ENTRY_W-1:0] head_data;
  logic               gate_accept;
  logic               gate_complete;

  logic               head_wr;
  logic [WSTRB_W-1:0] head_strb;
  logic [MEM_AW-1:0]  head_idx;
  logic [DATA_W-1:0]  head_wdata;

  logic [31:0] mem [2**MEM_AW];

  logic unused_bits;
  assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

`ifdef SRAM_RESP_RAND_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign gate_accept   = lfsr[0];
  assign gate_complete = lfsr[1];
`else
  logic unused_cfg;
  assign unused_cfg    = ^LFSR_SEED;
  assign gate_accept   = 1'b1;
  assign gate_complete = 1'b1;
`endif

  // Reset masks both handshakes so nothing retires during the clearing cycle
  assign addr_ok = !reset && req && !full && gate_accept;
  assign data_ok = !reset && !empty && head_ready && gate_complete;

  sram_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (addr_ok),
    .push_data  ({wr, wstrb, addr[MEM_AW+1:2], wdata}),
    .push_cnt   (INIT_CD),
    .pop        (data_ok),
    .full       (full),
    .empty      (empty),
    .head_ready (head_ready),
    .head_data  (head_data)
  );

  assign head_wr    = head_data[ENTRY_W-1];
  assign head_strb  = head_data[ENTRY_W-2 -: WSTRB_W];
  assign head_idx   = head_data[DATA_W +: MEM_AW];
  assign head_wdata = head_data[DATA_W-1:0];

  // Writes land when they retire, so later reads in the queue observe them
  always_ff @(posedge clk) begin
    if (data_ok && head_wr) begin
      for (int b = 0; b < WSTRB_W; b++) begin
        if (head_strb[b]) mem[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
      end
    end
  end

  assign rdata = (data_ok && !head_wr) ? mem[head_idx] : '0;

endmodule
